// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: groups every signal between the SDRAM command arbiter, the init
//   sequencer, the refresh/write/read engines and the SDRAM command/address pins.
// Ports: init_done/init_cmd/init_addr from the sequencer; <eng>_cmd/_addr/_done and
//   wr_req/rd_req from the engines; ref_en/wr_en/rd_en, ref_pending and
//   sdram_cmd/sdram_addr from the arbiter.
// Modports: master = the arbiter (drives grants and pins); slave = sequencer/engine side.
interface sdram_arbiter_if #(
    parameter int ASIZE = 12
);
    logic             init_done;
    logic [3:0]       init_cmd;
    logic [ASIZE-1:0] init_addr;
    logic [3:0]       ref_cmd;
    logic [ASIZE-1:0] ref_addr;
    logic [3:0]       wr_cmd;
    logic [ASIZE-1:0] wr_addr;
    logic [3:0]       rd_cmd;
    logic [ASIZE-1:0] rd_addr;
    logic             wr_req;
    logic             rd_req;
    logic             ref_done;
    logic             wr_done;
    logic             rd_done;
    logic             ref_en;
    logic             wr_en;
    logic             rd_en;
    logic             ref_pending;
    logic [3:0]       sdram_cmd;
    logic [ASIZE-1:0] sdram_addr;

    modport master (
        input  init_done, init_cmd, init_addr,
        input  ref_cmd, ref_addr, wr_cmd, wr_addr, rd_cmd, rd_addr,
        input  wr_req, rd_req, ref_done, wr_done, rd_done,
        output ref_en, wr_en, rd_en, ref_pending, sdram_cmd, sdram_addr
    );

    modport slave (
        output init_done, init_cmd, init_addr,
        output ref_cmd, ref_addr, wr_cmd, wr_addr, rd_cmd, rd_addr,
        output wr_req, rd_req, ref_done, wr_done, rd_done,
        input  ref_en, wr_en, rd_en, ref_pending, sdram_cmd, sdram_addr
    );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: owns the SDRAM command bus; init sequencer until init_done, then a
//   periodic auto-refresh tick and a grant to one of refresh/write/read engines.
// Latency: request sampled in IDLE at N -> enable at N+1, engine command on pins at N+2;
//   done at M -> enable low at M+1, so grants are always separated by a NOP cycle.
// Backpressure: requests are levels held until the enable is seen; a grant lasts until
//   the granted engine's done pulse. Ports: clk_100m, rst_n (async, active-low), bus
//   (sdram_arbiter_if.master). Optional: SDRAM_ARB_RR_EN = round-robin write/read ties.
module sdram_arbiter #(
    parameter int         ASIZE      = 12,
    parameter int         REF_PERIOD = 780,
    parameter logic [3:0] C_NOP      = 4'b0111
) (
    input  logic            clk_100m,
    input  logic            rst_n,
    sdram_arbiter_if.master bus
);
    typedef enum logic [2:0] {INIT, IDLE, REF, WR, RD} state_t;

    localparam int            TW   = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam logic [TW-1:0] TMAX = TW'(REF_PERIOD - 1);

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             ref_pending_q, ref_pending_d;
    logic             ref_en_q, wr_en_q, rd_en_q;
    logic [3:0]       cmd_q, cmd_d;
    logic [ASIZE-1:0] addr_q, addr_d;
    logic             wrap;
    logic             prefer_wr;

`ifdef SDRAM_ARB_RR_EN
    // Last-served flag: 1 = write, 0 = read. Starts as "read" so the first tie goes to write.
    logic last_wr_q, last_wr_d;

    assign prefer_wr = ~last_wr_q;

    always_comb begin
        last_wr_d = last_wr_q;
        if (state_q == IDLE && state_d == WR) last_wr_d = 1'b1;
        if (state_q == IDLE && state_d == RD) last_wr_d = 1'b0;
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) last_wr_q <= 1'b0;
        else        last_wr_q <= last_wr_d;
    end
`else
    assign prefer_wr = 1'b1;
`endif

    assign wrap = (state_q != INIT) && (timer_q == TMAX);

    // Next state: refresh beats write/read; only the granted engine's done returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT: if (bus.init_done) state_d = IDLE;
            IDLE: begin
                if (ref_pending_q)                              state_d = REF;
                else if (bus.wr_req && (!bus.rd_req || prefer_wr)) state_d = WR;
                else if (bus.rd_req)                            state_d = RD;
            end
            REF:     if (bus.ref_done) state_d = IDLE;
            WR:      if (bus.wr_done)  state_d = IDLE;
            RD:      if (bus.rd_done)  state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    // Refresh timer and the single outstanding-refresh flag. The set is applied after the
    // clear so a wrap on the very cycle REF is entered leaves a new refresh pending.
    always_comb begin
        timer_d       = timer_q;
        ref_pending_d = ref_pending_q;
        if (state_q == INIT || wrap) timer_d = '0;
        else                         timer_d = timer_q + 1'b1;
        if (state_q == IDLE && state_d == REF) ref_pending_d = 1'b0;
        if (wrap)                              ref_pending_d = 1'b1;
    end

    // Pin mux follows the current state; registered below, hence one cycle behind.
    always_comb begin
        cmd_d  = C_NOP;
        addr_d = '0;
        case (state_q)
            INIT: begin cmd_d = bus.init_cmd; addr_d = bus.init_addr; end
            REF:  begin cmd_d = bus.ref_cmd;  addr_d = bus.ref_addr;  end
            WR:   begin cmd_d = bus.wr_cmd;   addr_d = bus.wr_addr;   end
            RD:   begin cmd_d = bus.rd_cmd;   addr_d = bus.rd_addr;   end
            default: ;
        endcase
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= INIT;
            timer_q       <= '0;
            ref_pending_q <= 1'b0;
            ref_en_q      <= 1'b0;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            cmd_q         <= C_NOP;
            addr_q        <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ref_pending_q <= ref_pending_d;
            // Enables are flops of the next state so the engines see glitch-free grants.
            ref_en_q      <= (state_d == REF);
            wr_en_q       <= (state_d == WR);
            rd_en_q       <= (state_d == RD);
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
        end
    end

    assign bus.ref_en      = ref_en_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.ref_pending = ref_pending_q;
    assign bus.sdram_cmd   = cmd_q;
    assign bus.sdram_addr  = addr_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: table-driven vectors, hand-written refresh/round-robin/reset sequences
//   and a randomized phase, all checked against a grant-level reference model.
// The model derives refresh ticks arithmetically from the init_done cycle.
`timescale 1ns/1ps
module tb_sdram_arbiter;
    localparam int         ASIZE = 12;
    localparam int         P     = 780;
    localparam logic [3:0] NOP   = 4'b0111;
    localparam int G_NONE = 0, G_REF = 1, G_WR = 2, G_RD = 3;

    logic clk_100m = 1'b0;
    logic rst_n    = 1'b0;
    always #5 clk_100m = ~clk_100m;

    sdram_arbiter_if #(.ASIZE(ASIZE)) bus ();

    sdram_arbiter #(.ASIZE(ASIZE), .REF_PERIOD(P), .C_NOP(NOP)) dut (
        .clk_100m (clk_100m),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Reference model state (grant level)
    bit               m_init;
    int               m_grant;
    bit               m_pend;
    bit               m_lastwr;
    int               m_init_edge;
    logic [3:0]       m_cmd;
    logic [ASIZE-1:0] m_addr;

    logic [2:0] prev_en;
    int         gap_viol = 0;

    // Engine responders
    int wr_cnt = 0, rd_cnt = 0, ref_cnt = 0;
    int wr_len = 10, rd_len = 10, ref_len = 1;
    bit hold_reqs = 0, stray = 0, rand_len = 0;

    typedef struct {
        logic             init_done;
        logic [3:0]       icmd;
        logic [ASIZE-1:0] iaddr;
        logic             wr_req, rd_req, wr_done, rd_done, ref_done;
        logic [3:0]       ecmd;
        logic [ASIZE-1:0] eaddr;
        logic [2:0]       een;   // {ref_en, wr_en, rd_en}
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_init   = 1'b1;
        m_grant  = G_NONE;
        m_pend   = 1'b0;
        m_lastwr = 1'b0;
        m_cmd    = NOP;
        m_addr   = '0;
        prev_en  = 3'b000;
    endtask

    task automatic model_edge();
        bit tick, pw;
        if (m_init) begin
            m_cmd = bus.init_cmd; m_addr = bus.init_addr;
        end else begin
            case (m_grant)
                G_REF:   begin m_cmd = bus.ref_cmd; m_addr = bus.ref_addr; end
                G_WR:    begin m_cmd = bus.wr_cmd;  m_addr = bus.wr_addr;  end
                G_RD:    begin m_cmd = bus.rd_cmd;  m_addr = bus.rd_addr;  end
                default: begin m_cmd = NOP;         m_addr = '0;           end
            endcase
        end
        tick = !m_init && ((cyc - m_init_edge) % P == 0);
        pw = 1'b1;
`ifdef SDRAM_ARB_RR_EN
        pw = !m_lastwr;
`endif
        if (m_init) begin
            if (bus.init_done) begin m_init = 1'b0; m_init_edge = cyc; end
        end else if (m_grant == G_NONE) begin
            if (m_pend) begin m_grant = G_REF; m_pend = 1'b0; end
            else if (bus.wr_req && (!bus.rd_req || pw)) begin m_grant = G_WR; m_lastwr = 1'b1; end
            else if (bus.rd_req) begin m_grant = G_RD; m_lastwr = 1'b0; end
        end else if ((m_grant == G_REF && bus.ref_done) || (m_grant == G_WR && bus.wr_done) ||
                     (m_grant == G_RD && bus.rd_done)) begin
            m_grant = G_NONE;
        end
        if (tick) m_pend = 1'b1;
    endtask

    task automatic step();
        logic [2:0] cur;
        @(posedge clk_100m);
        #1;
        cyc++;
        model_edge();
        chk("model", 32'({bus.ref_en, bus.wr_en, bus.rd_en, bus.ref_pending, bus.sdram_cmd, bus.sdram_addr}),
            32'({m_grant == G_REF, m_grant == G_WR, m_grant == G_RD, m_pend, m_cmd, m_addr}));
        cur = {bus.ref_en, bus.wr_en, bus.rd_en};
        if ($countones(cur) > 1) gap_viol++;
        if (prev_en != 3'b000 && cur != 3'b000 && prev_en != cur) gap_viol++;
        prev_en = cur;
    endtask

    task automatic engines();
        if (bus.wr_en) begin wr_cnt++; if (!hold_reqs) bus.wr_req = 1'b0; end
        else begin wr_cnt = 0; if (rand_len) wr_len = $urandom_range(12, 1); end
        bus.wr_done = bus.wr_en ? (wr_cnt == wr_len) : (stray && $urandom_range(19) == 0);
        if (bus.rd_en) begin rd_cnt++; if (!hold_reqs) bus.rd_req = 1'b0; end
        else begin rd_cnt = 0; if (rand_len) rd_len = $urandom_range(12, 1); end
        bus.rd_done = bus.rd_en ? (rd_cnt == rd_len) : (stray && $urandom_range(19) == 0);
        if (bus.ref_en) ref_cnt++;
        else begin ref_cnt = 0; if (rand_len) ref_len = $urandom_range(6, 1); end
        bus.ref_done = bus.ref_en ? (ref_cnt == ref_len) : (stray && $urandom_range(19) == 0);
    endtask

    task automatic rand_inputs();
        bus.init_cmd  = 4'($urandom);  bus.init_addr = ASIZE'($urandom);
        bus.ref_cmd   = 4'($urandom);  bus.ref_addr  = ASIZE'($urandom);
        bus.wr_cmd    = 4'($urandom);  bus.wr_addr   = ASIZE'($urandom);
        bus.rd_cmd    = 4'($urandom);  bus.rd_addr   = ASIZE'($urandom);
        if (!bus.wr_en) begin
            if (!bus.wr_req) bus.wr_req = ($urandom_range(3) == 0);
            else if ($urandom_range(15) == 0) bus.wr_req = 1'b0;
        end
        if (!bus.rd_en) begin
            if (!bus.rd_req) bus.rd_req = ($urandom_range(3) == 0);
            else if ($urandom_range(15) == 0) bus.rd_req = 1'b0;
        end
        bus.init_done = ($urandom_range(63) == 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (bus.ref_en || bus.wr_en || bus.rd_en); i++) begin
            step(); engines();
        end
    endtask

    // Long write with a read waiting: refresh ticks land mid-write and REF must follow the write.
    task automatic seq_wr_ref(input string tag, input int start_off, input int len,
                              input int exp_refs, input bit exp_keep);
        int wr_fall, ref_rise, refs, n;
        bit pend_mid, keep, rd_seen;
        logic [2:0] pv;
        wr_fall = -1; ref_rise = -1; refs = 0; n = 0;
        pend_mid = 0; keep = 0; rd_seen = 0;
        ref_len = 1; wr_len = len; rd_len = 10;
        while ((cyc - m_init_edge) < start_off && n < 4000) begin step(); engines(); n++; end
        bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        pv = 3'b000;
        for (int i = 0; i < 2000 && !rd_seen; i++) begin
            step(); engines();
            if (bus.wr_en && bus.ref_pending) pend_mid = 1'b1;
            if (pv[1] && !bus.wr_en) wr_fall = cyc;
            if (!pv[2] && bus.ref_en) begin
                refs++;
                if (ref_rise < 0) begin ref_rise = cyc; keep = bus.ref_pending; end
            end
            if (bus.rd_en) rd_seen = 1'b1;
            pv = {bus.ref_en, bus.wr_en, bus.rd_en};
        end
        chk({tag, "_pend_mid_write"}, 32'(pend_mid), 32'd1);
        chk({tag, "_ref_after_wr"}, 32'(ref_rise - wr_fall), 32'd1);
        chk({tag, "_refs_before_rd"}, 32'(refs), 32'(exp_refs));
        chk({tag, "_pend_at_ref_entry"}, 32'(keep), 32'(exp_keep));
        chk({tag, "_rd_granted"}, 32'(rd_seen), 32'd1);
        drain();
    endtask

    initial begin
        int r1, r2, pr, ng, cnt;
        int g[4];
        int exp_g[4];
        logic [2:0] pv;

        bus.init_done = 0; bus.init_cmd = 4'h0; bus.init_addr = '0;
        bus.ref_cmd = 4'h1; bus.ref_addr = 12'h400;
        bus.wr_cmd  = 4'h4; bus.wr_addr  = 12'h0A1;
        bus.rd_cmd  = 4'h5; bus.rd_addr  = 12'h0B2;
        bus.wr_req = 0; bus.rd_req = 0; bus.ref_done = 0; bus.wr_done = 0; bus.rd_done = 0;
        model_reset();

        //           init icmd   iaddr    wr rd wd rd rfd  ecmd   eaddr    een
        tbl[0]  = '{1'b0, 4'h2, 12'h400, 0, 0, 0, 0, 0,  4'h2, 12'h400, 3'b000};
        tbl[1]  = '{1'b0, 4'h1, 12'h123, 1, 0, 0, 0, 0,  4'h1, 12'h123, 3'b000};
        tbl[2]  = '{1'b1, 4'h3, 12'h7FF, 1, 1, 0, 0, 0,  4'h3, 12'h7FF, 3'b000};
        tbl[3]  = '{1'b0, 4'h0, 12'h000, 1, 1, 0, 0, 0,  NOP,  12'h000, 3'b010};
        tbl[4]  = '{1'b0, 4'h0, 12'h000, 0, 1, 0, 0, 0,  4'h4, 12'h0A1, 3'b010};
        tbl[5]  = '{1'b0, 4'h0, 12'h000, 0, 1, 0, 1, 0,  4'h4, 12'h0A1, 3'b010};
        tbl[6]  = '{1'b0, 4'h0, 12'h000, 0, 1, 1, 0, 0,  4'h4, 12'h0A1, 3'b000};
        tbl[7]  = '{1'b0, 4'h0, 12'h000, 0, 1, 0, 0, 0,  NOP,  12'h000, 3'b001};
        tbl[8]  = '{1'b0, 4'h0, 12'h000, 0, 0, 0, 0, 0,  4'h5, 12'h0B2, 3'b001};
        tbl[9]  = '{1'b0, 4'h0, 12'h000, 0, 0, 0, 1, 0,  4'h5, 12'h0B2, 3'b000};
        tbl[10] = '{1'b0, 4'h0, 12'h000, 0, 0, 0, 0, 0,  NOP,  12'h000, 3'b000};
        tbl[11] = '{1'b1, 4'h0, 12'h000, 0, 0, 0, 0, 0,  NOP,  12'h000, 3'b000};
        tbl[12] = '{1'b0, 4'h0, 12'h000, 1, 0, 0, 0, 1,  NOP,  12'h000, 3'b010};
        tbl[13] = '{1'b0, 4'h0, 12'h000, 0, 0, 1, 0, 0,  4'h4, 12'h0A1, 3'b000};
        tbl[14] = '{1'b0, 4'h0, 12'h000, 0, 0, 0, 0, 0,  NOP,  12'h000, 3'b000};

        // Reset values
        repeat (2) @(posedge clk_100m);
        #1;
        chk("rst_cmd", 32'(bus.sdram_cmd), 32'(NOP));
        chk("rst_addr", 32'(bus.sdram_addr), 32'd0);
        chk("rst_en", 32'({bus.ref_en, bus.wr_en, bus.rd_en}), 32'd0);
        chk("rst_ref_pending", 32'(bus.ref_pending), 32'd0);
        @(negedge clk_100m);
        rst_n = 1'b1;

        // Table-driven vectors: INIT passthrough, grants, gaps, stray done pulses
        for (int i = 0; i < 15; i++) begin
            bus.init_done = tbl[i].init_done;
            bus.init_cmd  = tbl[i].icmd;   bus.init_addr = tbl[i].iaddr;
            bus.wr_req    = tbl[i].wr_req; bus.rd_req    = tbl[i].rd_req;
            bus.wr_done   = tbl[i].wr_done; bus.rd_done  = tbl[i].rd_done;
            bus.ref_done  = tbl[i].ref_done;
            step();
            chk($sformatf("tbl%0d", i),
                32'({bus.ref_en, bus.wr_en, bus.rd_en, bus.sdram_cmd, bus.sdram_addr}),
                32'({tbl[i].een, tbl[i].ecmd, tbl[i].eaddr}));
        end

        // Refresh periodicity with a prompt ref_done
        r1 = -1; r2 = -1; pr = -1; pv = 3'b000;
        for (int i = 0; i < 2000 && r2 < 0; i++) begin
            step(); engines();
            if (pr < 0 && bus.ref_pending) pr = cyc - m_init_edge;
            if (!pv[2] && bus.ref_en) begin
                if (r1 < 0) r1 = cyc - m_init_edge; else r2 = cyc - m_init_edge;
            end
            pv = {bus.ref_en, bus.wr_en, bus.rd_en};
        end
        chk("ref_pending_first_set", 32'(pr), 32'(P));
        chk("ref_en_first_rise", 32'(r1), 32'(P + 1));
        chk("ref_en_second_rise", 32'(r2), 32'(2 * P + 1));

        seq_wr_ref("long_wr", 3 * P - 10, 900, 1, 1'b0);
        seq_wr_ref("wrap_at_ref_entry", 5 * P - 10, 788, 2, 1'b1);

        // Both requests held for four operations
        hold_reqs = 1; wr_len = 10; rd_len = 10;
        bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        ng = 0; pv = 3'b000;
        for (int i = 0; i < 300 && ng < 4; i++) begin
            step(); engines();
            if (!pv[1] && bus.wr_en) begin g[ng] = G_WR; ng++; end
            if (!pv[0] && bus.rd_en && ng < 4) begin g[ng] = G_RD; ng++; end
            pv = {bus.ref_en, bus.wr_en, bus.rd_en};
        end
`ifdef SDRAM_ARB_RR_EN
        exp_g = '{G_WR, G_RD, G_WR, G_RD};
`else
        exp_g = '{G_WR, G_WR, G_WR, G_WR};
`endif
        chk("tie_grant_count", 32'(ng), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("tie_grant%0d", i), 32'(g[i]), 32'(exp_g[i]));
        bus.wr_req = 1'b0; bus.rd_req = 1'b0; hold_reqs = 0;
        drain();

        // Asynchronous reset while a read is granted
        bus.rd_req = 1'b1; rd_len = 50; cnt = 0;
        for (int i = 0; i < 50 && !bus.rd_en; i++) begin step(); engines(); end
        chk("rd_granted_before_reset", 32'(bus.rd_en), 32'd1);
        repeat (3) begin step(); engines(); end
        bus.rd_req = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rd_en", 32'({bus.ref_en, bus.wr_en, bus.rd_en}), 32'd0);
        chk("rst_mid_cmd", 32'(bus.sdram_cmd), 32'(NOP));
        chk("rst_mid_addr", 32'(bus.sdram_addr), 32'd0);
        chk("rst_mid_ref_pending", 32'(bus.ref_pending), 32'd0);
        model_reset();
        wr_cnt = 0; rd_cnt = 0; ref_cnt = 0;
        bus.wr_done = 0; bus.rd_done = 0; bus.ref_done = 0;
        @(negedge clk_100m);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.init_cmd = 4'($urandom); bus.init_addr = ASIZE'($urandom);
            step();
            if (bus.rd_en) cnt++;
        end
        chk("no_grant_before_init_done", 32'(cnt), 32'd0);
        bus.init_done = 1'b1;
        step();
        bus.init_done = 1'b0;
        step();
        chk("rd_after_fresh_init", 32'(bus.rd_en), 32'd1);

        // Randomized traffic against the model
        rand_len = 1; stray = 1;
        for (int i = 0; i < 4000; i++) begin
            step(); engines(); rand_inputs();
        end

        chk("onehot_and_gap", 32'(gap_viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
